// File: rtl/vx_mcommit_merge_pkg.sv
// Shared matrix commit definitions: instruction/type encodings, the expected
// micro-op count function and the per-warp merge context layout.
package vx_mcommit_merge_pkg;

  localparam int M_INSTR_BITS   = 3;
  localparam int M_TYPE_BITS    = 2;
  localparam int MC_NUM_THREADS = 4;
  localparam int MC_UUID_W      = 16;
  localparam int MC_CNT_W       = 4;

  localparam logic [M_INSTR_BITS-1:0] MLOAD_ID  = 3'd1;
  localparam logic [M_INSTR_BITS-1:0] MMUL_ID   = 3'd2;
  localparam logic [M_INSTR_BITS-1:0] MSTORE_ID = 3'd3;
  localparam logic [M_INSTR_BITS-1:0] MADD_ID   = 3'd4;

  localparam logic [M_TYPE_BITS-1:0] MATRIX_A = 2'd0;
  localparam logic [M_TYPE_BITS-1:0] MATRIX_B = 2'd1;
  localparam logic [M_TYPE_BITS-1:0] MATRIX_C = 2'd2;

  typedef struct packed {
    logic                          active;
    logic [MC_UUID_W-1:0]          uuid;
    logic [M_INSTR_BITS-1:0]       m_instr_id;
    logic [MC_CNT_W:0]             expect_cnt;
    logic [MC_NUM_THREADS-1:0]     tmask_acc;
    logic [(1<<MC_CNT_W)-1:0]      recv_mask;
    logic [MC_CNT_W:0]             recv_cnt;
  } mcommit_ctx_t;

  // Computed one bit wider than the row size so row_size+1 never wraps.
  function automatic logic [MC_CNT_W:0] mcommit_expect(
    input logic [M_INSTR_BITS-1:0] m_instr_id,
    input logic [M_TYPE_BITS-1:0]  m_type,
    input logic [MC_CNT_W-1:0]     row_size
  );
    logic [MC_CNT_W:0] cnt;
    cnt = (MC_CNT_W+1)'(1);
    if (m_instr_id == MLOAD_ID && (m_type == MATRIX_A || m_type == MATRIX_B))
      cnt = {1'b0, row_size};
    else if (m_instr_id == MMUL_ID)
      cnt = {1'b0, row_size} + 1'b1;
    return cnt;
  endfunction

endpackage

// File: rtl/vx_mcommit_ctx.sv
// One warp's merge context: records received micro-op indices and flags
// completion or a protocol violation for the beat routed to it.
module vx_mcommit_ctx
  import vx_mcommit_merge_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      beat_valid,
  input  logic [MC_UUID_W-1:0]      beat_uuid,
  input  logic [M_INSTR_BITS-1:0]   beat_instr_id,
  input  logic [MC_CNT_W:0]         beat_expect,
  input  logic [MC_NUM_THREADS-1:0] beat_tmask,
  input  logic [MC_CNT_W-1:0]       beat_idx,
  output logic                      beat_err,
  output logic                      done,
  output logic [M_INSTR_BITS-1:0]   done_instr_id,
  output logic [MC_CNT_W:0]         done_count,
  output logic [MC_NUM_THREADS-1:0] done_tmask
);

  mcommit_ctx_t ctx_q, ctx_d;
  logic [MC_CNT_W:0]         eff_expect;
  logic [MC_CNT_W:0]         cnt_next;
  logic [MC_NUM_THREADS-1:0] acc_tmask;

  always_ff @(posedge clk) begin
    if (reset) ctx_q <= '0;
    else       ctx_q <= ctx_d;
  end

  // Once active, the latched expectation governs the rest of the macro.
  always_comb begin
    eff_expect    = ctx_q.active ? ctx_q.expect_cnt : beat_expect;
    cnt_next      = ctx_q.active ? ctx_q.recv_cnt + 1'b1 : (MC_CNT_W+1)'(1);
    acc_tmask     = (ctx_q.active ? ctx_q.tmask_acc : '0) | beat_tmask;
    done_instr_id = ctx_q.active ? ctx_q.m_instr_id : beat_instr_id;
    done_count    = eff_expect;
    done_tmask    = acc_tmask;
    ctx_d         = ctx_q;
    beat_err      = 1'b0;
    done          = 1'b0;
    if (beat_valid) begin
      if (ctx_q.active && beat_uuid != ctx_q.uuid) begin
        beat_err = 1'b1;
      end else if ({1'b0, beat_idx} >= eff_expect) begin
        beat_err = 1'b1;
      end else if (ctx_q.active && ctx_q.recv_mask[beat_idx]) begin
        beat_err = 1'b1;
      end else if (cnt_next == eff_expect) begin
        done  = 1'b1;
        ctx_d = '0;
      end else begin
        ctx_d.active              = 1'b1;
        ctx_d.uuid                = beat_uuid;
        ctx_d.m_instr_id          = done_instr_id;
        ctx_d.expect_cnt          = eff_expect;
        ctx_d.recv_mask[beat_idx] = 1'b1;
        ctx_d.recv_cnt            = cnt_next;
        ctx_d.tmask_acc           = acc_tmask;
      end
    end
  end

endmodule

// File: rtl/vx_mcommit_merge.sv
// Merges matrix micro-op commits into one macro-commit per instruction;
// single-op commits bypass the per-warp contexts.
module vx_mcommit_merge
  import vx_mcommit_merge_pkg::*;
#(
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = MC_NUM_THREADS,
  parameter int UUID_W      = MC_UUID_W,
  parameter int CNT_W       = MC_CNT_W,
  parameter int WID_W       = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
)(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WID_W-1:0]        in_wid,
  input  logic [UUID_W-1:0]       in_uuid,
  input  logic [NUM_THREADS-1:0]  in_tmask,
  input  logic [M_INSTR_BITS-1:0] in_m_instr_id,
  input  logic [M_TYPE_BITS-1:0]  in_m_type,
  input  logic [CNT_W-1:0]        in_m_row_size,
  input  logic [CNT_W-1:0]        in_m_idx,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WID_W-1:0]        out_wid,
  output logic [UUID_W-1:0]       out_uuid,
  output logic [NUM_THREADS-1:0]  out_tmask,
  output logic [M_INSTR_BITS-1:0] out_m_instr_id,
  output logic [CNT_W:0]          out_count,
  output logic                    err
);

  logic                    beat_fire, bypass;
  logic [CNT_W:0]          beat_expect;
  logic [NUM_WARPS-1:0]    ctx_sel, ctx_err, ctx_done;
  logic [M_INSTR_BITS-1:0] ctx_id    [NUM_WARPS];
  logic [CNT_W:0]          ctx_count [NUM_WARPS];
  logic [NUM_THREADS-1:0]  ctx_tmask [NUM_WARPS];

  logic                    out_valid_q, out_valid_d;
  logic [WID_W-1:0]        out_wid_q, out_wid_d;
  logic [UUID_W-1:0]       out_uuid_q, out_uuid_d;
  logic [NUM_THREADS-1:0]  out_tmask_q, out_tmask_d;
  logic [M_INSTR_BITS-1:0] out_id_q, out_id_d;
  logic [CNT_W:0]          out_count_q, out_count_d;
  logic                    err_q, err_d;

  assign in_ready    = !out_valid_q || out_ready;
  assign beat_fire   = in_valid && in_ready;
  assign beat_expect = mcommit_expect(in_m_instr_id, in_m_type, in_m_row_size);
  assign bypass      = (beat_expect == (CNT_W+1)'(1));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WARPS; gi++) begin : g_ctx
      assign ctx_sel[gi] = beat_fire && !bypass && (in_wid == WID_W'(gi));
      vx_mcommit_ctx u_ctx (
        .clk           (clk),
        .reset         (reset),
        .beat_valid    (ctx_sel[gi]),
        .beat_uuid     (in_uuid),
        .beat_instr_id (in_m_instr_id),
        .beat_expect   (beat_expect),
        .beat_tmask    (in_tmask),
        .beat_idx      (in_m_idx),
        .beat_err      (ctx_err[gi]),
        .done          (ctx_done[gi]),
        .done_instr_id (ctx_id[gi]),
        .done_count    (ctx_count[gi]),
        .done_tmask    (ctx_tmask[gi])
      );
    end
  endgenerate

  // At most one context sees a beat per cycle, so in_wid selects the completer.
  always_comb begin
    out_valid_d = out_valid_q && !out_ready;
    out_wid_d   = out_wid_q;
    out_uuid_d  = out_uuid_q;
    out_tmask_d = out_tmask_q;
    out_id_d    = out_id_q;
    out_count_d = out_count_q;
    err_d       = err_q | (|ctx_err);
    if (beat_fire && bypass) begin
      out_valid_d = 1'b1;
      out_wid_d   = in_wid;
      out_uuid_d  = in_uuid;
      out_tmask_d = in_tmask;
      out_id_d    = in_m_instr_id;
      out_count_d = (CNT_W+1)'(1);
    end else if (|ctx_done) begin
      out_valid_d = 1'b1;
      out_wid_d   = in_wid;
      out_uuid_d  = in_uuid;
      out_tmask_d = ctx_tmask[in_wid];
      out_id_d    = ctx_id[in_wid];
      out_count_d = ctx_count[in_wid];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_wid_q   <= '0;
      out_uuid_q  <= '0;
      out_tmask_q <= '0;
      out_id_q    <= '0;
      out_count_q <= '0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_wid_q   <= out_wid_d;
      out_uuid_q  <= out_uuid_d;
      out_tmask_q <= out_tmask_d;
      out_id_q    <= out_id_d;
      out_count_q <= out_count_d;
      err_q       <= err_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_wid        = out_wid_q;
  assign out_uuid       = out_uuid_q;
  assign out_tmask      = out_tmask_q;
  assign out_m_instr_id = out_id_q;
  assign out_count      = out_count_q;
  assign err            = err_q;

endmodule
